// File: rtl/alu_wb_fifo_if.sv
// Handshake bundle between the ALU writeback buffer and its neighbours.
//   master : the side that offers ALU results and drains the head entry
//   slave  : the buffer itself (alu_wb_fifo)
// Signals:
//   in_valid/in_ready/in_f/in_flags/in_tag      result capture handshake
//   out_valid/out_ready/out_f/out_flags/out_tag register-file write handshake
//   count, sticky_c, sticky_v, drop_err         occupancy and sticky status
interface alu_wb_fifo_if #(
    parameter int DW   = 8,
    parameter int AW   = 2,
    parameter int TAGW = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_f;
    logic [5:0]      in_flags;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_f;
    logic [5:0]      out_flags;
    logic [TAGW-1:0] out_tag;
    logic [AW:0]     count;
    logic            sticky_c;
    logic            sticky_v;
    logic            drop_err;

    modport master (
        output in_valid, in_f, in_flags, in_tag, out_ready,
        input  in_ready, out_valid, out_f, out_flags, out_tag,
        input  count, sticky_c, sticky_v, drop_err
    );

    modport slave (
        input  in_valid, in_f, in_flags, in_tag, out_ready,
        output in_ready, out_valid, out_f, out_flags, out_tag,
        output count, sticky_c, sticky_v, drop_err
    );
endinterface

// File: rtl/alu_wb_fifo.sv
// Writeback buffer downstream of the 8-bit ALU. Each accepted result f, its
// flags {z,c,v,agtb,altb,aeqb} and a destination tag are stored in a
// first-word-fall-through FIFO and drained to the register-file write port
// with valid/ready, so a stalled writeback never loses an accepted result.
// Sticky status (carry seen, overflow seen, result dropped) is kept for the
// control unit and clears only on rst.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  alu_wb_fifo_if.slave (capture side, drain side, count, status)
module alu_wb_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int TAGW  = 3
) (
    input  logic         clk,
    input  logic         rst,
    alu_wb_fifo_if.slave bus
);
    localparam int EW = DW + 6 + TAGW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [EW-1:0]   mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic            sticky_c_r;
    logic            sticky_v_r;
    logic            drop_err_r;

    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    logic [EW-1:0]   head_s;

    // Status and handshake qualifiers; ready/valid depend on count only.
    always_comb begin
        full_s  = (count_r == FULL_CNT);
        empty_s = (count_r == {(AW + 1){1'b0}});
        push_s  = bus.in_valid & ~full_s;
        pop_s   = ~empty_s & bus.out_ready;
    end

    // Head entry falls through when occupied; zeros when empty so stale data never leaks.
    always_comb begin
        head_s = {EW{1'b0}};
        if (!empty_s) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = {EW{1'b0}};
        end
    end

    // Entry storage; cleared on reset so discarded results cannot reappear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.in_f, bus.in_flags, bus.in_tag};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {(AW + 1){1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky exception status; a drop is any offered result while full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_c_r <= 1'b0;
            sticky_v_r <= 1'b0;
            drop_err_r <= 1'b0;
        end else begin
            sticky_c_r <= sticky_c_r | (push_s & bus.in_flags[4]);
            sticky_v_r <= sticky_v_r | (push_s & bus.in_flags[3]);
            drop_err_r <= drop_err_r | (bus.in_valid & full_s);
        end
    end

    assign bus.in_ready  = ~full_s;
    assign bus.out_valid = ~empty_s;
    assign bus.out_f     = head_s[EW-1 -: DW];
    assign bus.out_flags = head_s[TAGW +: 6];
    assign bus.out_tag   = head_s[TAGW-1:0];
    assign bus.count     = count_r;
    assign bus.sticky_c  = sticky_c_r;
    assign bus.sticky_v  = sticky_v_r;
    assign bus.drop_err  = drop_err_r;
endmodule
